// File: rtl/pkt_stream_arbiter_if.sv
// Bus bundle for the two-requester packet arbiter: both input streams,
// the downstream FIFO write port, the current grant and the per-requester packet counters.
interface pkt_stream_arbiter_if #(
   parameter int WIDTH  = 256,
   parameter int KEEP_W = WIDTH / 8,
   parameter int CNT_W  = 16
);
   logic              s0_valid;
   logic [WIDTH-1:0]  s0_data;
   logic [KEEP_W-1:0] s0_keep;
   logic              s0_last;
   logic              s0_ready;

   logic              s1_valid;
   logic [WIDTH-1:0]  s1_data;
   logic [KEEP_W-1:0] s1_keep;
   logic              s1_last;
   logic              s1_ready;

   logic              fifo_wr_en;
   logic [WIDTH-1:0]  fifo_wr_data;
   logic [KEEP_W-1:0] fifo_wr_keep;
   logic              fifo_wr_last;
   logic              fifo_full;

   logic [1:0]        grant;
   logic [CNT_W-1:0]  pkt_cnt0;
   logic [CNT_W-1:0]  pkt_cnt1;

   modport master (
      output s0_valid, s0_data, s0_keep, s0_last,
      output s1_valid, s1_data, s1_keep, s1_last,
      output fifo_full,
      input  s0_ready, s1_ready,
      input  fifo_wr_en, fifo_wr_data, fifo_wr_keep, fifo_wr_last,
      input  grant, pkt_cnt0, pkt_cnt1
   );

   modport slave (
      input  s0_valid, s0_data, s0_keep, s0_last,
      input  s1_valid, s1_data, s1_keep, s1_last,
      input  fifo_full,
      output s0_ready, s1_ready,
      output fifo_wr_en, fifo_wr_data, fifo_wr_keep, fifo_wr_last,
      output grant, pkt_cnt0, pkt_cnt1
   );
endinterface

// File: rtl/pkt_stream_arbiter.sv
// Packet-locked two-way arbiter into a FIFO: one idle bubble on first grant, then zero-latency
// combinational data path; fifo_full stalls everything, hand-off on last beat has no bubble.
module pkt_stream_arbiter #(
   parameter int WIDTH  = 256,
   parameter int KEEP_W = WIDTH / 8,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pkt_stream_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              prio;
   logic              prio_nxt;
   logic [CNT_W-1:0]  cnt0;
   logic [CNT_W-1:0]  cnt1;
   logic              inc0;
   logic              inc1;
   logic              ready0;
   logic              ready1;
   logic              wr_en;
   logic [WIDTH-1:0]  wr_data;
   logic [KEEP_W-1:0] wr_keep;
   logic              wr_last;

   // prio=1 favours s1 when both request.
   function automatic state_t pick(input logic v0, input logic v1, input logic p);
      if (v0 && (!v1 || !p)) return GNT0;
      if (v1) return GNT1;
      return IDLE;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         prio  <= 1'b0;
         cnt0  <= '0;
         cnt1  <= '0;
      end else begin
         state <= state_nxt;
         prio  <= prio_nxt;
         if (inc0) cnt0 <= cnt0 + 1'b1;
         if (inc1) cnt1 <= cnt1 + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      prio_nxt  = prio;
      inc0      = 1'b0;
      inc1      = 1'b0;
      ready0    = 1'b0;
      ready1    = 1'b0;
      wr_en     = 1'b0;
      wr_data   = '0;
      wr_keep   = '0;
      wr_last   = 1'b0;
      unique case (state)
         IDLE: state_nxt = pick(bus.s0_valid, bus.s1_valid, prio);
         GNT0: begin
            ready0  = !bus.fifo_full;
            wr_en   = bus.s0_valid && !bus.fifo_full;
            wr_data = bus.s0_data;
            wr_keep = bus.s0_keep;
            wr_last = bus.s0_last;
            // Last beat: flip priority and re-arbitrate in the same cycle.
            if (wr_en && bus.s0_last) begin
               inc0      = 1'b1;
               prio_nxt  = 1'b1;
               state_nxt = pick(bus.s0_valid, bus.s1_valid, 1'b1);
            end
         end
         GNT1: begin
            ready1  = !bus.fifo_full;
            wr_en   = bus.s1_valid && !bus.fifo_full;
            wr_data = bus.s1_data;
            wr_keep = bus.s1_keep;
            wr_last = bus.s1_last;
            if (wr_en && bus.s1_last) begin
               inc1      = 1'b1;
               prio_nxt  = 1'b0;
               state_nxt = pick(bus.s0_valid, bus.s1_valid, 1'b0);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.grant        = {state == GNT1, state == GNT0};
   assign bus.s0_ready     = ready0;
   assign bus.s1_ready     = ready1;
   assign bus.fifo_wr_en   = wr_en;
   assign bus.fifo_wr_data = wr_data;
   assign bus.fifo_wr_keep = wr_keep;
   assign bus.fifo_wr_last = wr_last;
   assign bus.pkt_cnt0     = cnt0;
   assign bus.pkt_cnt1     = cnt1;
endmodule
